// File: rtl/sbox_ran_prng.sv
// ---------------------------------------------------------------------------
// sbox_ran_prng
//
// Randomness source for the 2-share masked AES S-box. A 128-bit Fibonacci
// LFSR (taps 127,125,100,98) is seeded with four 32-bit beats, warmed up for
// WARMUP advances, and then delivers one fresh 30-bit word per consumed
// cycle. One "advance" is 30 LFSR steps unrolled into a single cycle.
//
// Parameters:
//   WARMUP      number of advances between the 4th seed beat and the first
//               valid word (legal 1..255)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   seed_word   32-bit seed beat; the first beat ends up in s[127:96]
//   seed_valid  seed beat present
//   seed_ready  seed beat accepted this cycle (low only during warm-up)
//   ran_en      consumer takes the current word; LFSR advances (RUN only)
//   ran         registered 30-bit randomness word, 0 while ran_valid is low
//   ran_valid   ran holds a fresh word from a seeded, warmed-up LFSR
// ---------------------------------------------------------------------------
module sbox_ran_prng #(
   parameter int WARMUP = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seed_word,
   input  logic        seed_valid,
   output logic        seed_ready,
   input  logic        ran_en,
   output logic [29:0] ran,
   output logic        ran_valid
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WARM,
      RUN
   } state_t;

   localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

   state_t       state;
   state_t       state_nxt;
   logic [127:0] s;
   logic [127:0] s_nxt;
   logic [127:0] s_adv;
   logic [127:0] s_shift;
   logic [29:0]  ran_nxt;
   logic         ran_valid_nxt;
   logic [2:0]   beat_cnt;
   logic [2:0]   beat_cnt_nxt;
   logic [7:0]   warm_cnt;
   logic [7:0]   warm_cnt_nxt;
   logic         accept;

   // Thirty LFSR steps chained combinationally. Bits fed back during the
   // chain only reach positions 0..29, so they never feed a tap within the
   // same advance; the low 30 bits of the result are the fresh word.
   function automatic logic [127:0] advance30(input logic [127:0] x);
      logic [127:0] y;
      y = x;
      for (int i = 0; i < 30; i++) begin
         y = {y[126:0], y[127] ^ y[125] ^ y[100] ^ y[98]};
      end
      return y;
   endfunction

   // Both candidate next states of the LFSR: one full advance, or a seed
   // beat shifted in from the bottom.
   assign s_adv   = advance30(s);
   assign s_shift = {s[95:0], seed_word};

   // Next-state logic. Seed acceptance takes priority over ran_en in RUN,
   // so a simultaneous consume and reseed never produces a word. The 4th
   // beat replaces an all-zero state with 1 so the LFSR cannot lock up.
   always_comb begin
      state_nxt     = state;
      s_nxt         = s;
      ran_nxt       = ran;
      ran_valid_nxt = ran_valid;
      beat_cnt_nxt  = beat_cnt;
      warm_cnt_nxt  = warm_cnt;
      seed_ready    = (state != WARM);
      accept        = seed_valid && (state != WARM);

      unique case (state)
         IDLE: begin
            if (accept) begin
               s_nxt        = s_shift;
               beat_cnt_nxt = 3'd1;
               state_nxt    = LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               s_nxt        = s_shift;
               beat_cnt_nxt = beat_cnt + 3'd1;
               if (beat_cnt == 3'd3) begin
                  if (s_shift == '0) begin
                     s_nxt = 128'h1;
                  end
                  warm_cnt_nxt = 8'd0;
                  state_nxt    = WARM;
               end
            end
         end
         WARM: begin
            s_nxt        = s_adv;
            warm_cnt_nxt = warm_cnt + 8'd1;
            if (warm_cnt == WARM_LAST) begin
               ran_nxt       = s_adv[29:0];
               ran_valid_nxt = 1'b1;
               state_nxt     = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               s_nxt         = s_shift;
               beat_cnt_nxt  = 3'd1;
               ran_nxt       = '0;
               ran_valid_nxt = 1'b0;
               state_nxt     = LOAD;
            end else if (ran_en) begin
               s_nxt   = s_adv;
               ran_nxt = s_adv[29:0];
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register. Reset clears everything, discarding any partial seed
   // or warm-up, and returns to IDLE ready for a new seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         s         <= '0;
         ran       <= '0;
         ran_valid <= 1'b0;
         beat_cnt  <= 3'd0;
         warm_cnt  <= 8'd0;
      end else begin
         state     <= state_nxt;
         s         <= s_nxt;
         ran       <= ran_nxt;
         ran_valid <= ran_valid_nxt;
         beat_cnt  <= beat_cnt_nxt;
         warm_cnt  <= warm_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_sbox_ran_prng.sv
// ---------------------------------------------------------------------------
// tb_sbox_ran_prng
//
// Two instances share the clock and reset: dut_a uses the default warm-up of
// 16 advances, dut_b uses a warm-up of 1 so first words can be worked out by
// hand. With WARMUP=1 the first word is ran[j] = s[98+j]^s[96+j]^s[71+j]^
// s[69+j] of the seeded state, which is where the table values come from.
// ---------------------------------------------------------------------------
module tb_sbox_ran_prng;

   logic        clk;
   logic        rst;

   logic [31:0] a_seed_word;
   logic        a_seed_valid;
   logic        a_seed_ready;
   logic        a_ran_en;
   logic [29:0] a_ran;
   logic        a_ran_valid;

   logic [31:0] b_seed_word;
   logic        b_seed_valid;
   logic        b_seed_ready;
   logic        b_ran_en;
   logic [29:0] b_ran;
   logic        b_ran_valid;

   int checks;
   int passes;

   sbox_ran_prng dut_a (
      .clk        (clk),
      .rst        (rst),
      .seed_word  (a_seed_word),
      .seed_valid (a_seed_valid),
      .seed_ready (a_seed_ready),
      .ran_en     (a_ran_en),
      .ran        (a_ran),
      .ran_valid  (a_ran_valid)
   );

   sbox_ran_prng #(.WARMUP(1)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .seed_word  (b_seed_word),
      .seed_valid (b_seed_valid),
      .seed_ready (b_seed_ready),
      .ran_en     (b_ran_en),
      .ran        (b_ran),
      .ran_valid  (b_ran_valid)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] seed;
      int           gap;
      logic         ran_en_during_seed;
      logic [29:0]  exp_ran;
   } vec_t;

   vec_t vecs [7];

   // Reference LFSR: one step, and n advances of 30 steps each.
   function automatic logic [127:0] ref_step(input logic [127:0] x);
      return {x[126:0], x[127] ^ x[125] ^ x[100] ^ x[98]};
   endfunction

   function automatic logic [127:0] ref_adv(input logic [127:0] x, input int n);
      logic [127:0] y;
      y = x;
      for (int i = 0; i < n * 30; i++) begin
         y = ref_step(y);
      end
      return y;
   endfunction

   // Advance to just after the next rising edge, where outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic a_beat(input logic [31:0] w, input int gap);
      int waited;
      waited = 0;
      a_seed_word  = w;
      a_seed_valid = 1'b1;
      while (!a_seed_ready && waited < 64) begin
         tick();
         waited++;
      end
      check_output("a_seed_ready_for_beat", a_seed_ready, 1);
      tick();
      a_seed_valid = 1'b0;
      a_seed_word  = '0;
      repeat (gap) tick();
   endtask

   task automatic b_beat(input logic [31:0] w, input int gap);
      int waited;
      waited = 0;
      b_seed_word  = w;
      b_seed_valid = 1'b1;
      while (!b_seed_ready && waited < 64) begin
         tick();
         waited++;
      end
      check_output("b_seed_ready_for_beat", b_seed_ready, 1);
      tick();
      b_seed_valid = 1'b0;
      b_seed_word  = '0;
      repeat (gap) tick();
   endtask

   // Counts edges (from a starting count) until dut_a raises ran_valid,
   // giving up after a bounded number of cycles.
   task automatic a_wait_valid(input int start, output int cyc);
      cyc = start;
      while (!a_ran_valid && cyc < 64) begin
         tick();
         cyc++;
      end
   endtask

   task automatic apply_stimulus();
      logic [127:0] m;
      logic [127:0] nseed;
      int           cyc;

      // Reset state of both instances.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_output("a_reset_ran", a_ran, 0);
      check_output("a_reset_valid", a_ran_valid, 0);
      check_output("a_reset_ready", a_seed_ready, 1);
      check_output("a_reset_s", dut_a.s, 0);
      check_output("b_reset_ran", b_ran, 0);
      check_output("b_reset_valid", b_ran_valid, 0);

      // Table of hand-computed first words on the WARMUP=1 instance.
      for (int i = 0; i < 7; i++) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         b_ran_en = vecs[i].ran_en_during_seed;
         b_beat(vecs[i].seed[127:96], vecs[i].gap);
         b_beat(vecs[i].seed[95:64], vecs[i].gap);
         b_beat(vecs[i].seed[63:32], vecs[i].gap);
         b_beat(vecs[i].seed[31:0], 0);
         check_output($sformatf("b_vec%0d_valid_low", i), b_ran_valid, 0);
         tick();
         check_output($sformatf("b_vec%0d_valid", i), b_ran_valid, 1);
         check_output($sformatf("b_vec%0d_first_word", i), b_ran, vecs[i].exp_ran);
         m = (vecs[i].seed == '0) ? 128'h1 : vecs[i].seed;
         m = ref_adv(m, 2);
         b_ran_en = 1'b1;
         tick();
         b_ran_en = 1'b0;
         check_output($sformatf("b_vec%0d_second_word", i), b_ran, m[29:0]);
      end

      // Zero seed: lockout fix, then the single 1 walks up into the taps.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b_beat(32'h0, 0);
      b_beat(32'h0, 0);
      b_beat(32'h0, 0);
      b_beat(32'h0, 0);
      check_output("b_zero_forced_state", dut_b.s, 128'h1);
      tick();
      check_output("b_zero_valid", b_ran_valid, 1);
      check_output("b_zero_word0", b_ran, 30'h0);
      b_ran_en = 1'b1;
      tick();
      check_output("b_zero_word1", b_ran, 30'h0);
      tick();
      check_output("b_zero_word2", b_ran, 30'h0);
      tick();
      check_output("b_zero_word3", b_ran, 30'h0280000);
      b_ran_en = 1'b0;

      // Default warm-up, seed 1,0,0,0 back to back.
      a_beat(32'h1, 0);
      a_beat(32'h0, 0);
      a_beat(32'h0, 0);
      a_beat(32'h0, 0);
      check_output("a_seeded_state", dut_a.s, {32'h1, 96'h0});
      a_wait_valid(0, cyc);
      check_output("a_latency", cyc, 16);
      m = ref_adv({32'h1, 96'h0}, 16);
      check_output("a_word0", a_ran, m[29:0]);
      a_ran_en = 1'b1;
      for (int w = 1; w <= 1000; w++) begin
         if (w == 500) begin
            a_ran_en = 1'b0;
            for (int k = 0; k < 5; k++) begin
               tick();
               check_output("a_hold_ran", a_ran, m[29:0]);
               check_output("a_hold_s", dut_a.s, m);
            end
            a_ran_en = 1'b1;
         end
         tick();
         m = ref_adv(m, 1);
         check_output($sformatf("a_word%0d", w), a_ran, m[29:0]);
      end
      check_output("a_valid_after_stream", a_ran_valid, 1);

      // Reseed in the same cycle as ran_en: seed wins, nothing advances.
      a_seed_word  = 32'hDEADBEEF;
      a_seed_valid = 1'b1;
      check_output("a_run_ready", a_seed_ready, 1);
      tick();
      a_seed_valid = 1'b0;
      a_ran_en     = 1'b0;
      check_output("a_reseed_valid", a_ran_valid, 0);
      check_output("a_reseed_ran", a_ran, 0);
      check_output("a_reseed_no_advance", dut_a.s, {m[95:0], 32'hDEADBEEF});
      tick();
      a_beat(32'h12345678, 2);
      a_beat(32'hCAFEF00D, 3);
      a_beat(32'h0BADC0DE, 0);
      nseed = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};

      // Seed beat offered throughout part of warm-up must not be taken.
      a_seed_word  = 32'hFFFF0000;
      a_seed_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         check_output("a_warm_ready_low", a_seed_ready, 0);
         tick();
         check_output($sformatf("a_warm_s%0d", k), dut_a.s, ref_adv(nseed, k));
      end
      a_seed_valid = 1'b0;
      a_seed_word  = '0;
      a_wait_valid(10, cyc);
      check_output("a_reseed_latency", cyc, 16);
      m = ref_adv(nseed, 16);
      check_output("a_reseed_word0", a_ran, m[29:0]);
      a_ran_en = 1'b1;
      for (int w = 1; w <= 8; w++) begin
         tick();
         m = ref_adv(m, 1);
         check_output($sformatf("a_reseed_word%0d", w), a_ran, m[29:0]);
      end

      // Reset for two cycles mid-RUN, then ran_en pulses must do nothing.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_output("a_midrun_reset_ran", a_ran, 0);
      check_output("a_midrun_reset_valid", a_ran_valid, 0);
      check_output("a_midrun_reset_ready", a_seed_ready, 1);
      check_output("a_midrun_reset_s", dut_a.s, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_output("a_idle_ran_en_ran", a_ran, 0);
         check_output("a_idle_ran_en_valid", a_ran_valid, 0);
         check_output("a_idle_ran_en_s", dut_a.s, 0);
      end
      a_ran_en = 1'b0;
   endtask

   initial begin
      checks       = 0;
      passes       = 0;
      rst          = 1'b1;
      a_seed_word  = '0;
      a_seed_valid = 1'b0;
      a_ran_en     = 1'b0;
      b_seed_word  = '0;
      b_seed_valid = 1'b0;
      b_ran_en     = 1'b0;

      vecs[0] = '{seed: {32'h00000001, 96'h0}, gap: 0, ran_en_during_seed: 1'b0, exp_ran: 30'h0A000001};
      vecs[1] = '{seed: {32'h0, 32'h80000000, 64'h0}, gap: 1, ran_en_during_seed: 1'b1, exp_ran: 30'h05000000};
      vecs[2] = '{seed: {32'h80000000, 96'h0}, gap: 2, ran_en_during_seed: 1'b0, exp_ran: 30'h20000000};
      vecs[3] = '{seed: {128{1'b1}}, gap: 3, ran_en_during_seed: 1'b1, exp_ran: 30'h0};
      vecs[4] = '{seed: 128'h0, gap: 0, ran_en_during_seed: 1'b1, exp_ran: 30'h0};
      vecs[5] = '{seed: {32'h00000004, 96'h0}, gap: 1, ran_en_during_seed: 1'b0, exp_ran: 30'h28000005};
      vecs[6] = '{seed: {32'h00000003, 96'h0}, gap: 0, ran_en_during_seed: 1'b1, exp_ran: 30'h1E000003};

      apply_stimulus();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sbox_ran_prng.md
# sbox_ran_prng

Masked-randomness source sitting directly upstream of the 2-share masked AES S-box. It holds a 128-bit Fibonacci LFSR and delivers 30 fresh bits per cycle on the S-box `ran[29:0]` bus. The LFSR is seeded over a 32-bit valid/ready port and runs a warm-up phase before the first output. The S-box consumes one 30-bit word per cycle. Each advance of `ran_en` produces a new word.

## Interface
- `WARMUP`, default 16: number of 30-step LFSR advances executed after seeding and before `ran_valid` rises; legal range 1..255.
- `clk` input 1: single clock, all flops rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `seed_word` input 32: seed beat.
- `seed_valid` input 1: seed beat present.
- `seed_ready` output 1: block accepts a seed beat this cycle.
- `ran_en` input 1: consumer takes current `ran`; LFSR advances.
- `ran` output 30: randomness word, wired to the S-box `ran` input.
- `ran_valid` output 1: `ran` holds fresh seeded output.

## Operation
- LFSR state `s[127:0]`.
- Single step:
  - `fb = s[127]^s[125]^s[100]^s[98]`
  - `s <= {s[126:0], fb}`
- An "advance" is 30 single steps unrolled in one cycle (combinational chain, one register stage).
- Seed beat: `s <= {s[95:0], seed_word}`. The first beat ends up in `s[127:96]` after 4 beats.
- If the 4th beat leaves `s == 0`, state is forced to `128'h1` at the same edge. This zero-seed lockout fix is mandatory.
- FSM states:
  - IDLE: reset state.
    - `seed_ready=1`, `ran_valid=0`.
    - Accepted beat → LOAD, beat count = 1.
  - LOAD:
    - `seed_ready=1`.
    - Count beats 1..4. 4th accepted beat → WARM, warm counter = 0.
    - No timeout; LOAD waits indefinitely.
  - WARM:
    - `seed_ready=0`.
    - Advance every cycle, counter +1.
    - On the advance with counter = `WARMUP-1` → RUN. At that same edge `ran <= s_next[29:0]` and `ran_valid <= 1`.
  - RUN:
    - `seed_ready=1`, `ran_valid=1`.
    - `ran_en=1`: advance, `ran <= s_next[29:0]`.
    - `ran_en=0`: `s` and `ran` hold.
    - Accepted seed beat → LOAD, beat count = 1, beat shifted in, `ran_valid <= 0`, `ran <= 0`.
- Simultaneous `ran_en` and an accepted seed beat in RUN: the seed wins. No advance occurs and no fresh word is produced.
- `ran` is a dedicated register, never combinationally gated. It is 0 whenever `ran_valid=0`.
- `ran_en` is ignored outside RUN.
- `seed_valid` is ignored in WARM and no beat is consumed. The source must hold the beat until `seed_ready`.

## Timing
- Reset values:
  - `s=0`
  - `ran=0`
  - `ran_valid=0`
  - `seed_ready=1` (IDLE)
  - beat count = 0
  - warm counter = 0
- `rst` asserted in any state returns to IDLE at the next edge and discards any partial seed or warm-up.
- Latency: `ran_valid` rises exactly `WARMUP` cycles after the edge that accepted beat 4. With back-to-back beats this is 4+`WARMUP` edges after the first beat.
- Throughput: one new 30-bit word per cycle while `ran_en=1`. The word on `ran` at an edge with `ran_en=1` is consumed, and the next word appears after that edge.
- A reseed drops `ran_valid` at the accepting edge. Output resumes `WARMUP` cycles after the new 4th beat.
- No output word is ever repeated across an advance. With `ran_en=0`, the word is held, so the S-box must only sample when it asserts `ran_en`.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-RUN → `ran=0`, `ran_valid=0`, `seed_ready=1`, state IDLE; subsequent `ran_en` pulses change nothing.
- **Zero seed, `WARMUP=1`:** 4 beats of `32'h0` → `ran_valid=1` one cycle after beat 4 with `ran=30'h0`. Hold `ran_en=1`; successive words are `30'h0`, `30'h0`, then `30'h0280000`.
- **Back-pressure:** in RUN, drive `ran_en=0` for 5 cycles → `ran` and internal `s` are unchanged; on re-enable, the sequence continues exactly where it paused, compared against the C reference model.
- **Reseed priority:** in RUN, assert `seed_valid` and `ran_en` in the same cycle → `ran_valid=0`, `ran=0`, no advance; after 3 more beats plus `WARMUP` cycles, the output equals the model seeded with the new 4 beats.
- **Gapped seeding:** beats with 1–3 idle cycles between them, plus `seed_valid` asserted during WARM → gaps do not change the result, no beat is consumed in WARM, and `seed_ready=0` throughout WARM.
- **Default `WARMUP=16`, seed `32'h00000001`,`0`,`0`,`0`:** `ran_valid` rises exactly 16 cycles after beat 4; 1000 words match the model bit-for-bit.
